// File: rtl/grf_write_scheduler_pkg.sv
// Shared types and constants for the GRF write-port scheduler.
package grf_write_scheduler_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int ENTRY_W = 37;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } sched_state_t;

  // One buffered aux result: destination register and data.
  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
  } grf_entry_t;

endpackage

// File: rtl/grf_write_scheduler_if.sv
// Bus bundle between the pipeline/aux source and the GRF write scheduler.
interface grf_write_scheduler_if;

  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic        aux_valid;
  logic [4:0]  aux_a3;
  logic [31:0] aux_wd;
  logic        aux_ready;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        busy_rs;
  logic        busy_rt;
  logic        pipe_stall;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;

  modport master (
    output wb_we, wb_a3, wb_wd, aux_valid, aux_a3, aux_wd, q_rs, q_rt,
    input  aux_ready, busy_rs, busy_rt, pipe_stall, grf_we, grf_a3, grf_wd
  );

  modport slave (
    input  wb_we, wb_a3, wb_wd, aux_valid, aux_a3, aux_wd, q_rs, q_rt,
    output aux_ready, busy_rs, busy_rt, pipe_stall, grf_we, grf_a3, grf_wd
  );

endinterface

// File: rtl/grf_write_scheduler_aux_wb_fifo.sv
// Small FIFO holding aux results until the GRF write port is free.
// Exposes per-entry valid/a3 so the top can build the busy scoreboard.
module aux_wb_fifo
  import grf_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  grf_entry_t           din,
  output grf_entry_t           head,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH-1:0]     entry_valid,
  output logic [DEPTH*5-1:0]   entry_a3
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [DEPTH-1:0] valid_q;
  grf_entry_t       mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign entry_valid = valid_q;

  // Pointers and per-entry valid bits; reset discards anything pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        valid_q[rd_ptr[AW-1:0]] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
        valid_q[wr_ptr[AW-1:0]] <= 1'b1;
      end
    end
  end

  // Entry storage needs no reset: the valid bits say what is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Flatten the destination fields for the busy compare in the top.
  always_comb begin
    entry_a3 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_a3[i*5 +: 5] = mem[i].a3;
    end
  end

endmodule

// File: rtl/grf_write_scheduler.sv
// Arbitrates the single GRF write port between write-back and a buffered
// aux result source, forcing a one-cycle freeze if the aux head starves.
module grf_write_scheduler
  import grf_write_scheduler_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  grf_write_scheduler_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  sched_state_t       state;
  sched_state_t       state_next;
  logic [CW-1:0]      starve_cnt;
  logic [CW-1:0]      starve_next;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  grf_entry_t         fifo_din;
  grf_entry_t         fifo_head;
  logic [DEPTH-1:0]   entry_valid;
  logic [DEPTH*5-1:0] entry_a3;
  logic               wb_writing;
  logic               aux_accept;
  logic               hit_rs;
  logic               hit_rt;

  // Writes to $0 are dropped: WB to $0 is not a write, aux to $0 is acked but not stored.
  assign wb_writing    = bus.wb_we && (bus.wb_a3 != REG_ZERO);
  assign bus.aux_ready = !fifo_full;
  assign aux_accept    = bus.aux_valid && !fifo_full;
  assign fifo_push     = aux_accept && (bus.aux_a3 != REG_ZERO);
  assign fifo_din      = '{a3: bus.aux_a3, wd: bus.aux_wd};

  aux_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .pop         (fifo_pop),
    .din         (fifo_din),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_a3    (entry_a3)
  );

  // Write-port selection: DRAIN forces the aux head, otherwise WB has priority.
  always_comb begin
    fifo_pop       = 1'b0;
    bus.grf_we     = 1'b0;
    bus.grf_a3     = REG_ZERO;
    bus.grf_wd     = '0;
    bus.pipe_stall = 1'b0;
    if (state == DRAIN) begin
      bus.pipe_stall = 1'b1;
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        bus.grf_we = 1'b1;
        bus.grf_a3 = fifo_head.a3;
        bus.grf_wd = fifo_head.wd;
      end
    end else if (wb_writing) begin
      bus.grf_we = 1'b1;
      bus.grf_a3 = bus.wb_a3;
      bus.grf_wd = bus.wb_wd;
    end else if (!fifo_empty) begin
      fifo_pop   = 1'b1;
      bus.grf_we = 1'b1;
      bus.grf_a3 = fifo_head.a3;
      bus.grf_wd = fifo_head.wd;
    end
  end

  // Starvation counting and the NORMAL/DRAIN decision.
  always_comb begin
    starve_next = starve_cnt;
    state_next  = NORMAL;
    if (fifo_pop || fifo_empty) begin
      starve_next = '0;
    end else if (starve_cnt != LIMIT) begin
      starve_next = starve_cnt + CW'(1);
    end
    if ((state == NORMAL) && (starve_next == LIMIT)) begin
      state_next = DRAIN;
    end
  end

  // State and starve counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Busy scoreboard: any stored entry or an accepted push targeting the queried register.
  always_comb begin
    hit_rs = aux_accept && (bus.aux_a3 == bus.q_rs);
    hit_rt = aux_accept && (bus.aux_a3 == bus.q_rt);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_a3[i*5 +: 5] == bus.q_rs)) hit_rs = 1'b1;
      if (entry_valid[i] && (entry_a3[i*5 +: 5] == bus.q_rt)) hit_rt = 1'b1;
    end
    bus.busy_rs = (bus.q_rs != REG_ZERO) && hit_rs;
    bus.busy_rt = (bus.q_rt != REG_ZERO) && hit_rt;
  end

endmodule

// File: doc/grf_write_scheduler.md
Name: grf_write_scheduler

Overview:
- Owns the single GRF write port (A3/WD/WE3). Shares it between the pipeline write-back stage and an auxiliary multi-cycle result source, such as a future mult/div or coprocessor unit.
- Aux results are buffered in a small FIFO and written in slots where the WB stage does not write.
- A starvation counter forces a one-cycle pipeline freeze so aux results always drain.
- Also exports a busy scoreboard so decode can stall on registers with pending aux writes.

Parameters:
- DEPTH, 2: aux FIFO entries, a power of 2 and at least 2.
- STARVE_LIMIT, 4: consecutive cycles the FIFO head may wait before a forced drain; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wb_we  in  1  WB stage write enable (the WE3 produced by write-back).
- wb_a3  in  5  WB destination register.
- wb_wd  in  32  WB write data.
- aux_valid  in  1  aux result offered.
- aux_a3  in  5  aux destination register.
- aux_wd  in  32  aux write data.
- aux_ready  out  1  FIFO can accept an aux result.
- q_rs  in  5  decode query: rs field.
- q_rt  in  5  decode query: rt field.
- busy_rs  out  1  q_rs has a pending aux write.
- busy_rt  out  1  q_rt has a pending aux write.
- pipe_stall  out  1  freeze the whole pipeline, including the WB register, this cycle.
- grf_we  out  1  GRF write enable.
- grf_a3  out  5  GRF write address.
- grf_wd  out  32  GRF write data.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, rd/wr pointers 0, starve counter 0, state NORMAL. Outputs then read aux_ready=1, pipe_stall=0, busy_*=0. With wb_we=0, grf_we=0. Entries pending at reset are discarded; no partial write ever occurs.
- Writes to $0 are non-writes.
  - WB with wb_a3=0 is treated as wb_we=0.
  - An aux push with aux_a3=0 is accepted (handshake completes) but not enqueued.
  - grf_wd is 0 whenever grf_a3=0.
- Push: on the clk rising edge when aux_valid && aux_ready. aux_ready = !full, computed from pre-edge state only; a same-cycle pop does not raise it.
- Latency: there is no aux bypass. The earliest GRF write of an aux result is the cycle after its push.
- FSM states: NORMAL and DRAIN (registered).
- Port selection is combinational from the registered state:
  - DRAIN: write the FIFO head and pop it. WB is ignored and pipe_stall=1, so the held WB instruction retries next cycle.
  - NORMAL, WB writing: write the WB value; pipe_stall=0.
  - NORMAL, WB not writing and FIFO non-empty: write the head and pop it.
  - Otherwise: grf_we=0.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Clears on any pop, or when the FIFO is empty.
  - Increments when the FIFO is non-empty and no pop occurs; saturates at STARVE_LIMIT.
- Transitions:
  - NORMAL -> DRAIN at the edge where the counter's next value equals STARVE_LIMIT.
  - DRAIN -> NORMAL after exactly one cycle, with the counter cleared.
  - pipe_stall is high for exactly one cycle per drain.
- Busy outputs: busy_rs=1 when q_rs!=0 and q_rs matches aux_a3 of any valid FIFO entry or of a push this cycle; busy_rt likewise for q_rt. Decode must stall on busy. The block does no WB/aux ordering checks; hazard avoidance is the issuer's job through the busy outputs.
- Pointers wrap modulo DEPTH. Full/empty are tracked with an extra pointer bit.

Decomposition:
- Shared package:
  - REG_ZERO = 5'd0.
  - Sched state encoding: NORMAL=0, DRAIN=1.
  - Entry layout {a3[4:0], wd[31:0]}: 37 bits.
- Sub-module aux_wb_fifo:
  - Parameterized by DEPTH.
  - Ports: push, pop, din, head, full, empty, and a flat per-entry valid/a3 vector for the busy compare.

Test Plan:
1. Reset, then release reset with idle inputs -> aux_ready=1, grf_we=0, pipe_stall=0, busy_rs=busy_rt=0.
2. wb_we=0; push aux {a3=5, wd=32'hDEAD_BEEF} at cycle N -> cycle N+1: grf_we=1, grf_a3=5, grf_wd=32'hDEADBEEF; busy_rs for q_rs=5 is 1 at N and N+1 and 0 at N+2.
3. Push 2 aux entries with wb_we=1 (a3=8) held every cycle -> aux_ready=0 after the 2 pushes. After STARVE_LIMIT=4 waiting cycles, pipe_stall=1 for 1 cycle and the first aux entry is written. Counter restarts; the second entry drains 5 cycles later, then aux_ready=1.
4. Aux push with a3=0 and wd=32'h1234 -> handshake completes, FIFO stays empty, grf_we stays 0. Separately, wb_we=1 with wb_a3=0 -> grf_we=0.
5. FIFO full and wb_we=0, with aux_valid=1 -> head pops, aux_ready stays 0 that cycle and the new value is not accepted. It is accepted the next cycle; FIFO order is preserved (writes come out a3=1, 2, 3).
6. reset=0 asserted mid-cycle while in DRAIN with 2 entries -> pipe_stall, grf_we and busy_* drop immediately; after release, FIFO is empty and no stale write appears.
